data_mem_resp: RTL

- Memory-side responder for the data-cache miss/write-through bus (m_a, m_din, m_strobe, m_rw -> m_dout, m_ready).
- Accepts one request at a time and inserts a programmable number of wait states.
- Services the request from an internal word-addressed RAM, then pulses m_ready for one cycle.
- Sits between the data cache (or uncached path) and the memory array; it replaces the idealised memory in the pipelined FPU/cache/TLB core.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_array.sv | 29 ++
 rtl/data_mem_resp.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory responder.
//   state_e    - responder FSM encoding (IDLE / WAIT / DONE), 2 bits
//   RW_READ    - m_rw value for a read request
//   RW_WRITE   - m_rw value for a write request
//   CNT_W      - width of the wait-state down-counter
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port 2^ADDR_BITS x 32 word RAM.
//   clk    in   clock; writes happen on the rising edge
//   we     in   write enable
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data, combinational from addr
module mem_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset; clearing it would need one write per word
  // and its contents must survive clr anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: memory-side responder for the data-cache miss /
// write-through bus. Accepts one request at a time, inserts WAIT_CYCLES
// wait states, services it from mem_array and pulses m_ready for one cycle.
//
// Optional feature macro: MEM_ALIGN_CHK_EN
//   defined   - requests with m_a[1:0] != 0 complete with m_err = 1, writes
//               are suppressed and reads return 0.
//   undefined - m_a[1:0] is ignored and m_err stays 0.
//
// Ports:
//   clk       in   clock
//   clr       in   synchronous active-high reset
//   m_a       in   byte address (word index = m_a[ADDR_BITS+1:2])
//   m_din     in   write data
//   m_strobe  in   request valid, held by the initiator until m_ready
//   m_rw      in   1 = write, 0 = read
//   m_dout    out  read data, valid with m_ready, held until the next read
//   m_ready   out  one-cycle completion pulse
//   m_err     out  misalignment error, qualified by m_ready
//   busy      out  high while a request is in WAIT or DONE
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] m_a,
  input  logic [31:0] m_din,
  input  logic        m_strobe,
  input  logic        m_rw,
  output logic [31:0] m_dout,
  output logic        m_ready,
  output logic        m_err,
  output logic        busy
);

`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [ADDR_BITS-1:0] idx_q,   idx_d;
  logic [1:0]           lo_q,    lo_d;
  logic [31:0]          din_q,   din_d;
  logic                 rw_q,    rw_d;
  logic [31:0]          dout_q,  dout_d;

  // Address bits above the RAM window alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^m_a[31:ADDR_BITS+2];

  // In IDLE the request being accepted may go straight to DONE
  // (WAIT_CYCLES = 0), so the RAM is addressed from the live inputs there and
  // from the request register everywhere else.
  logic                 in_idle;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [1:0]           acc_lo;
  logic                 acc_rw;
  logic                 acc_mis;
  logic [31:0]          rdata;
  logic                 mem_we;

  assign in_idle = (state_q == S_IDLE);
  assign acc_idx = in_idle ? m_a[ADDR_BITS+1:2] : idx_q;
  assign acc_lo  = in_idle ? m_a[1:0]           : lo_q;
  assign acc_rw  = in_idle ? m_rw               : rw_q;
  assign acc_mis = ALIGN_CHK && (acc_lo != 2'b00);

  // The write lands at the edge leaving DONE; a reset at that edge aborts it.
  assign mem_we = (state_q == S_DONE) && (rw_q == RW_WRITE) && !acc_mis && !clr;

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_idx),
    .wdata (din_q),
    .rdata (rdata)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    din_d   = din_q;
    rw_d    = rw_q;
    dout_d  = dout_q;

    unique case (state_q)
      S_IDLE: begin
        if (m_strobe) begin
          idx_d = m_a[ADDR_BITS+1:2];
          lo_d  = m_a[1:0];
          din_d = m_din;
          rw_d  = m_rw;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // Strobe seen here belongs to the finished request; ignore it.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is captured on entry to DONE; writes leave m_dout untouched.
    if ((state_d == S_DONE) && (state_q != S_DONE) && (acc_rw == RW_READ)) begin
      dout_d = acc_mis ? 32'h0 : rdata;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      din_q   <= '0;
      rw_q    <= RW_READ;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      din_q   <= din_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
    end
  end

  assign m_dout  = dout_q;
  assign m_ready = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign m_err   = (state_q == S_DONE) && acc_mis;

endmodule
